// File: rtl/pipeline_control_unit_if.sv
// Hazard-control bundle between the pipeline stages and pipeline_control_unit.
// Latency: none, wires only.
// Backpressure: stall/bubble/flush controls are the backpressure seen by the stages.
interface pipeline_control_unit_if;
   // Hazard sources reported by the stages
   logic [4:0] id_src1_i;
   logic       id_src1_used_i;
   logic [4:0] id_src2_i;
   logic       id_src2_used_i;
   logic       ex_load_i;
   logic [4:0] ex_dest_i;
   logic       mem_access_i;
   logic       mem_ready_i;
   logic       branch_taken_i;
   logic       ext_stall_i;

   // Per-stage controls returned to the pipeline
   logic       stall_if_o;
   logic       stall_id_o;
   logic       stall_ex_o;
   logic       stall_mem_o;
   logic       bubble_ex_o;
   logic       flush_if_o;
   logic       flush_id_o;
   logic       mem_timeout_o;

   // Pipeline side: reports hazards, receives controls
   modport master (
      output id_src1_i, id_src1_used_i, id_src2_i, id_src2_used_i,
             ex_load_i, ex_dest_i, mem_access_i, mem_ready_i,
             branch_taken_i, ext_stall_i,
      input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
             bubble_ex_o, flush_if_o, flush_id_o, mem_timeout_o
   );

   // Controller side
   modport slave (
      input  id_src1_i, id_src1_used_i, id_src2_i, id_src2_used_i,
             ex_load_i, ex_dest_i, mem_access_i, mem_ready_i,
             branch_taken_i, ext_stall_i,
      output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
             bubble_ex_o, flush_if_o, flush_id_o, mem_timeout_o
   );
endinterface

// File: rtl/pipeline_control_unit.sv
// Five-stage pipeline hazard controller: load interlock, bus-wait freeze, branch flush, bus timeout.
// Latency: stall/bubble/flush are combinational (same cycle); state and counters update on the clock.
// Backpressure: a bus wait or external freeze stalls every stage; a load-use hazard stalls IF/ID only.
// Optional: define PIPELINE_STATS_EN to add stall/interlock/flush performance counters.
module pipeline_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   pipeline_control_unit_if.slave    ctl
`ifdef PIPELINE_STATS_EN
   ,
   input  logic                      stats_clear_i,
   output logic [31:0]               stall_cycles_o,
   output logic [31:0]               interlock_count_o,
   output logic [31:0]               flush_count_o
`endif
);

   localparam logic [15:0] LP_TIMEOUT    = 16'(MEM_TIMEOUT);
   localparam logic [15:0] LP_TIMEOUT_M1 = LP_TIMEOUT - 16'd1;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_refill_pending;
   logic [15:0] r_wait_cnt;
   logic        r_mem_timeout;

   logic        w_bus_wait;
   logic        w_full_stall;
   logic        w_src1_haz;
   logic        w_src2_haz;
   logic        w_load_use;
   logic        w_branch_ok;
   logic        w_interlock;

   // r0 is hardwired zero, so a load targeting it never feeds anything
   assign w_src1_haz   = ctl.id_src1_used_i & (ctl.id_src1_i == ctl.ex_dest_i);
   assign w_src2_haz   = ctl.id_src2_used_i & (ctl.id_src2_i == ctl.ex_dest_i);
   assign w_load_use   = ctl.ex_load_i & (ctl.ex_dest_i != 5'd0) & (w_src1_haz | w_src2_haz);

   // mem_ready_i only matters while the memory stage is actually on the bus
   assign w_bus_wait   = ctl.mem_access_i & ~ctl.mem_ready_i;
   assign w_full_stall = w_bus_wait | ctl.ext_stall_i;

   // A frozen execute stage repeats its branch, so only act on it when unstalled;
   // a taken branch makes the interlocked decode instruction wrong-path anyway
   assign w_branch_ok  = ctl.branch_taken_i & ~w_full_stall;
   assign w_interlock  = w_load_use & ~w_full_stall & ~ctl.branch_taken_i;

   // Next-state logic for the bus-wait tracker
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:      if (w_bus_wait) w_state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (ctl.mem_ready_i || !ctl.mem_access_i) w_state_nxt = ST_RUN;
         default:     w_state_nxt = ST_RUN;
      endcase
   end

   // Per-stage controls; everything is held low while reset is asserted
   always_comb begin
      ctl.stall_if_o    = 1'b0;
      ctl.stall_id_o    = 1'b0;
      ctl.stall_ex_o    = 1'b0;
      ctl.stall_mem_o   = 1'b0;
      ctl.bubble_ex_o   = 1'b0;
      ctl.flush_if_o    = 1'b0;
      ctl.flush_id_o    = 1'b0;
      ctl.mem_timeout_o = 1'b0;
      if (reset_i) begin
         ctl.stall_if_o    = w_full_stall | w_interlock;
         ctl.stall_id_o    = w_full_stall | w_interlock;
         ctl.stall_ex_o    = w_full_stall;
         ctl.stall_mem_o   = w_full_stall;
         ctl.bubble_ex_o   = w_interlock;
         ctl.flush_if_o    = w_branch_ok | (r_refill_pending & ~w_full_stall);
         ctl.flush_id_o    = w_branch_ok;
         ctl.mem_timeout_o = r_mem_timeout;
      end
   end

   // State, refill tracking and the saturating bus-wait timer
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         r_state          <= ST_RUN;
         r_refill_pending <= 1'b0;
         r_wait_cnt       <= 16'd0;
         r_mem_timeout    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // One extra IF flush after a branch discards the fetch already in flight;
         // a back-to-back branch simply re-arms it
         if (!w_full_stall) begin
            r_refill_pending <= ctl.branch_taken_i;
         end
         // Every cycle that ends waiting on the bus counts; leaving the wait resets the timer
         if (w_state_nxt == ST_MEM_WAIT) begin
            if (r_wait_cnt != LP_TIMEOUT) begin
               r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (r_wait_cnt == LP_TIMEOUT_M1) begin
               r_mem_timeout <= 1'b1;
            end
         end else begin
            r_wait_cnt <= 16'd0;
         end
      end
   end

`ifdef PIPELINE_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_interlock_count;
   logic [31:0] r_flush_count;

   // Free-running event counters; clear takes priority over counting
   always_ff @(posedge clock_i) begin
      if (!reset_i || stats_clear_i) begin
         r_stall_cycles    <= 32'd0;
         r_interlock_count <= 32'd0;
         r_flush_count     <= 32'd0;
      end else begin
         if (w_full_stall) r_stall_cycles    <= r_stall_cycles + 32'd1;
         if (w_interlock)  r_interlock_count <= r_interlock_count + 32'd1;
         if (w_branch_ok)  r_flush_count     <= r_flush_count + 32'd1;
      end
   end

   assign stall_cycles_o    = reset_i ? r_stall_cycles    : 32'd0;
   assign interlock_count_o = reset_i ? r_interlock_count : 32'd0;
   assign flush_count_o     = reset_i ? r_flush_count     : 32'd0;
`endif

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central hazard and sequencing controller for the five-stage integer pipeline. Each cycle it evaluates load-use hazards, memory-stage bus waits, external stalls and taken branches, then drives per-stage stall, bubble and flush controls to fetch, decode, execute and memory. It sits beside `instruction_decode_unit` and replaces the stall/flush logic scattered across the stages. A sticky timeout flag catches hung bus transactions.

## Interface
- `MEM_TIMEOUT`, 255: bus-wait cycles before `mem_timeout_o` sets (1..65535).
- `clock_i` in 1: clock, rising edge.
- `reset_i` in 1: synchronous, active-low reset.
- `id_src1_i` in 5: decode-stage source register 1.
- `id_src1_used_i` in 1: decode instruction reads src1.
- `id_src2_i` in 5: decode-stage source register 2.
- `id_src2_used_i` in 1: decode instruction reads src2.
- `ex_load_i` in 1: execute-stage instruction is a load.
- `ex_dest_i` in 5: execute-stage destination register.
- `mem_access_i` in 1: memory-stage instruction is on the bus.
- `mem_ready_i` in 1: bus transaction completes this cycle.
- `branch_taken_i` in 1: execute stage resolved a taken branch/jump.
- `ext_stall_i` in 1: external freeze (debug halt).
- `stall_if_o`, `stall_id_o`, `stall_ex_o`, `stall_mem_o` out 1 each: hold stage register.
- `bubble_ex_o` out 1: load NOP into the execute register.
- `flush_if_o`, `flush_id_o` out 1 each: replace stage contents with NOP.
- `mem_timeout_o` out 1: sticky bus-timeout flag.

## Operation
- `full_stall = (mem_access_i & ~mem_ready_i) | ext_stall_i`.
  - Asserts all four `stall_*_o`.
  - Suppresses `bubble_ex_o`.
  - Blocks branch and interlock evaluation, because execute is frozen and `branch_taken_i` repeats.
- Load interlock, when not `full_stall`:
  - Condition: `ex_load_i` and (`id_src1_used_i` & `id_src1_i == ex_dest_i` & `ex_dest_i != 0`, or the same for src2).
  - Response: `stall_if_o = stall_id_o = 1`, `bubble_ex_o = 1`, for one cycle.
- Branch, when not `full_stall`:
  - `branch_taken_i` asserts `flush_if_o` and `flush_id_o`, and sets `refill_pending`.
  - The branch outranks the interlock; the interlocked instruction is on the wrong path.
- Refill, when `refill_pending` is set and not `full_stall`:
  - `flush_if_o = 1` discards the wrong-path fetch already in flight.
  - `refill_pending` clears.
  - A new `branch_taken_i` in the same cycle re-arms `refill_pending`.
- Flush outranks stall on the same stage: when both apply, the flush output asserts and the stall output also stays asserted.
- FSM states: RUN and MEM_WAIT.
  - RUN → MEM_WAIT when `mem_access_i & ~mem_ready_i`.
  - MEM_WAIT → RUN on `mem_ready_i`, or when `mem_access_i` drops.
  - `ext_stall_i` alone does not leave RUN.
- Timeout counter (16 bit):
  - Increments each cycle in MEM_WAIT and clears on exit.
  - At `MEM_TIMEOUT` it saturates and sets `mem_timeout_o`.
  - `mem_timeout_o` clears only on reset.
- Register 0 never creates a hazard.

## Timing
- All stall, flush and bubble outputs are combinational from the current inputs plus registered state (same-cycle response).
- State, `refill_pending`, counters and `mem_timeout_o` update on the rising edge.
- Reset, while `reset_i` = 0 at an edge:
  - FSM enters RUN.
  - `refill_pending`, timeout counter and `mem_timeout_o` become 0.
  - All outputs are forced to 0 while `reset_i` is low.
  - Reset mid-wait or mid-refill abandons the operation with no residual flush.
- `mem_ready_i` is sampled only when `mem_access_i` is 1. A completion with zero wait never enters MEM_WAIT.
- Branch and full stall in the same cycle: no flush. The flush fires on the first unstalled cycle.

## Configuration
- `PIPELINE_STATS_EN` defined: adds performance counters.
  - Extra ports: `stats_clear_i` in 1, `stall_cycles_o` out 32, `interlock_count_o` out 32, `flush_count_o` out 32.
  - `stall_cycles_o` counts `full_stall` cycles.
  - `interlock_count_o` counts bubbles.
  - `flush_count_o` counts accepted branches.
  - Counters wrap at 2^32, clear on reset or `stats_clear_i`; clear wins over increment.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Load-use: `ex_load_i=1`, `ex_dest_i=5`, `id_src2_i=5`, `id_src2_used_i=1` -> `stall_if_o`, `stall_id_o`, `bubble_ex_o` = 1 for exactly that cycle; repeat with `ex_dest_i=0` -> no stall.
- Bus wait: `mem_access_i=1`, `mem_ready_i=0` for 4 cycles, then 1 -> all stalls high for 4 cycles, low on the ready cycle; FSM back to RUN.
- Branch: `branch_taken_i` one cycle -> `flush_if_o` and `flush_id_o` that cycle, `flush_if_o` only the next cycle, then idle.
- Branch under stall: `branch_taken_i=1` with `ext_stall_i=1` for 3 cycles -> no flush; flush on the first cycle with `ext_stall_i=0`.
- Timeout with `MEM_TIMEOUT=8`: `mem_ready_i` held 0 -> `mem_timeout_o` rises after 8 wait cycles, stays 1 after ready, clears only after reset.
- With `PIPELINE_STATS_EN`: run the scenarios above -> `stall_cycles_o`, `interlock_count_o`, `flush_count_o` match exact counts; `stats_clear_i` -> all 0.
